// File: rtl/regfile_scanner.sv
// Walks registers 0..NREGS-1 through a shared synchronous read port and streams {addr, data} out.
// Three cycles per register when grant and ready are both high; stalls in RD on lost grant and in HOLD on backpressure.
module regfile_scanner #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          rf_req,
  input  logic          rf_grant,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, RD, CAP, HOLD} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] index;
  logic [AW-1:0] raddr_q;
  logic          hs;

  assign hs       = out_valid & out_ready;
  assign busy     = (state != IDLE);
  assign rf_req   = (state == RD);
  // Address follows index only while requesting; otherwise it parks on the last value driven.
  assign rf_raddr = rf_req ? index : raddr_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RD;
      RD:   if (rf_grant) state_nxt = CAP;
      CAP:  state_nxt = HOLD;
      HOLD: if (hs) state_nxt = (index == LAST) ? IDLE : RD;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index     <= '0;
      raddr_q   <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      done    <= 1'b0;
      raddr_q <= rf_raddr;
      if (abort && state != IDLE) begin
        index     <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) index <= '0;
          CAP: begin
            out_data  <= rf_rdata;
            out_addr  <= index;
            out_valid <= 1'b1;
          end
          HOLD: if (hs) begin
            out_valid <= 1'b0;
            if (index == LAST) done  <= 1'b1;
            else               index <= index + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_scanner.sv
// Directed bench for regfile_scanner: behavioural regfile, in-order sample scoreboard, timing and control checks.
module tb_regfile_scanner;

  logic        clk = 1'b0;
  logic        rst, start, abort, rf_grant, out_ready;
  logic        busy, done, rf_req, out_valid;
  logic [4:0]  rf_raddr, out_addr;
  logic [31:0] rf_rdata, out_data;

  int errors = 0;
  int checks = 0;
  int exp_next = 0;

  regfile_scanner #(.NREGS(32), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .rf_req(rf_req), .rf_grant(rf_grant), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Register file: reg[i] = 0xA5A50000 + i, r0 reads 0, one-cycle registered read.
  always @(posedge clk)
    rf_rdata <= (rf_raddr == 5'd0) ? 32'h0 : (32'hA5A50000 | {27'd0, rf_raddr});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted sample must be the next index with its regfile value.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [4:0] ea;
      ea = exp_next[4:0];
      check("sample_addr", out_addr, ea);
      check("sample_data", out_data, (ea == 5'd0) ? 32'h0 : (32'hA5A50000 | {27'd0, ea}));
      exp_next++;
    end
    if (!rst && done) check("done_excl_valid", out_valid, 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    exp_next = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_rd(input logic [4:0] a);
    int n = 0;
    while (!(rf_req && rf_raddr == a) && n < 300) begin tick(); n++; end
    if (n >= 300) check("wait_rd_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_sample(input logic [4:0] a);
    int n = 0;
    while (!(out_valid && out_addr == a) && n < 300) begin tick(); n++; end
    if (n >= 300) check("wait_sample_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin tick(); n++; end
    if (n >= 400) check("wait_done_timeout", 1'b0, 1'b1);
    check("sample_count", exp_next, 32);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rf_grant = 1'b1; out_ready = 1'b1;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", rf_req, 0);
    check("rst_raddr", rf_raddr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr", out_addr, 0);
    check("rst_data", out_data, 0);

    // Full scan with cycle-exact timing: start sampled in cycle 0.
    exp_next = 0;
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      start = 1'b0;
      check($sformatf("scan_valid_c%0d", c), out_valid, (c >= 3 && c <= 96 && c % 3 == 0));
      check($sformatf("scan_done_c%0d", c), done, (c == 97));
      check($sformatf("scan_busy_c%0d", c), busy, (c <= 96));
      if (c == 1) check("scan_c1_raddr", rf_raddr, 0);
      if (c == 3) check("scan_c3_data", out_data, 32'h0);
      if (c == 96) begin
        check("scan_c96_addr", out_addr, 31);
        check("scan_c96_data", out_data, 32'hA5A5001F);
      end
    end
    check("scan_count", exp_next, 32);

    // Grant withheld for 4 cycles at index 5.
    pulse_start();
    wait_rd(5'd5);
    rf_grant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("contend_req", rf_req, 1);
      check("contend_raddr", rf_raddr, 5);
      check("contend_valid", out_valid, 0);
      tick();
    end
    rf_grant = 1'b1;
    wait_sample(5'd5);
    check("contend_data5", out_data, 32'hA5A50005);
    wait_done();

    // Backpressure for 10 cycles on sample 7.
    pulse_start();
    wait_sample(5'd7);
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", out_valid, 1);
      check("bp_addr", out_addr, 7);
      check("bp_data", out_data, 32'hA5A50007);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_req", rf_req, 1);
    check("bp_next_raddr", rf_raddr, 8);
    check("bp_next_valid", out_valid, 0);
    wait_done();

    // Abort while holding sample 12; the held sample is dropped.
    pulse_start();
    wait_sample(5'd12);
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_req", rf_req, 0);
    for (int k = 0; k < 3; k++) begin
      check("abort_no_done", done, 0);
      tick();
    end
    check("abort_count", exp_next, 12);
    pulse_start();
    check("rescan_raddr0", rf_raddr, 0);
    wait_done();

    // start while busy must not restart or disturb the scan.
    pulse_start();
    wait_sample(5'd3);
    start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    wait_done();

    // Sync reset in CAP at index 20.
    pulse_start();
    wait_rd(5'd20);
    tick();
    check("cap_valid_low", out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_req", rf_req, 0);
    check("mrst_raddr", rf_raddr, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_addr", out_addr, 0);
    check("mrst_data", out_data, 0);

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_req", rf_req, 0);
    tick();
    check("sa_busy2", busy, 0);
    check("sa_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
